// File: rtl/axis_result_checker_if.sv
// AXI-Stream bundle used by the result checker: one instance per direction.
// TID is carried for uniformity with the rest of the mesh; the checker only drives it on its master side.
interface axis_result_checker_if #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2
);
    logic              TVALID;
    logic              TREADY;
    logic [TDATAW-1:0] TDATA;
    logic              TLAST;
    logic [TDESTW-1:0] TDEST;
    logic [TIDW-1:0]   TID;

    modport master (
        output TVALID,
        output TDATA,
        output TLAST,
        output TDEST,
        output TID,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TLAST,
        input  TDEST,
        output TREADY
    );
endinterface

// File: rtl/axis_result_checker.sv
// Terminal AXI-Stream consumer: sums NUM_PACKETS result packets, counts malformed ones,
// then emits a two-flit summary (sum, then {err_cnt, pkt_cnt}) and pulses DONE.
module axis_result_checker #(
    parameter int               TDATAW        = 32,
    parameter int               TDESTW        = 4,
    parameter int               TIDW          = 2,
    parameter int               NUM_PACKETS   = 4,
    parameter int               EXP_LEN       = 2,
    parameter logic [TDESTW-1:0] MY_ADDR      = 4'd3,
    parameter logic [TDESTW-1:0] SUMMARY_DEST = 4'd0,
    parameter logic [7:0]       READY_PATTERN = 8'hFF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    output logic                  DONE,
    axis_result_checker_if.slave  AXIS_S,
    axis_result_checker_if.master AXIS_M
);

    typedef enum logic [1:0] {IDLE, RECV, SUM0, SUM1} state_t;

    state_t            r_state;
    logic [7:0]        r_mask;
    logic [TDATAW-1:0] r_sum;
    logic [15:0]       r_pkt_cnt;
    logic [15:0]       r_err_cnt;
    logic [7:0]        r_flit_cnt;
    logic              r_pkt_bad;
    logic              r_s_tready;
    logic              r_m_tvalid;
    logic [TDATAW-1:0] r_m_tdata;
    logic              r_m_tlast;
    logic              r_done;

    logic              w_s_acc;
    logic [TDATAW-1:0] w_sum_next;
    logic              w_dest_bad;
    logic              w_len_ok;
    logic              w_pkt_err;
    logic [15:0]       w_pkt_next;
    logic              w_last_pkt;
    logic [TDATAW-1:0] w_flit1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_s_acc    = (r_state == RECV) && AXIS_S.TVALID && r_s_tready;
    assign w_sum_next = r_sum + AXIS_S.TDATA;
    assign w_dest_bad = (AXIS_S.TDEST != MY_ADDR);
    // 9-bit compare so a saturated flit count (255 + 1) can never alias a legal length
    assign w_len_ok   = (({1'b0, r_flit_cnt} + 9'd1) == EXP_LEN[8:0]);
    assign w_pkt_err  = !w_len_ok || r_pkt_bad || w_dest_bad;
    assign w_pkt_next = r_pkt_cnt + 16'd1;
    assign w_last_pkt = (w_pkt_next == NUM_PACKETS[15:0]);

    always_comb begin
        w_flit1        = '0;
        w_flit1[31:0]  = {r_err_cnt, r_pkt_cnt};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_mask     <= READY_PATTERN;
            r_sum      <= '0;
            r_pkt_cnt  <= '0;
            r_err_cnt  <= '0;
            r_flit_cnt <= '0;
            r_pkt_bad  <= 1'b0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_s_tready <= 1'b0;
                    if (START) begin
                        r_sum      <= '0;
                        r_pkt_cnt  <= '0;
                        r_err_cnt  <= '0;
                        r_flit_cnt <= '0;
                        r_pkt_bad  <= 1'b0;
                        r_mask     <= READY_PATTERN;
                        r_s_tready <= READY_PATTERN[0];
                        r_state    <= RECV;
                    end
                end
                RECV: begin
                    // Throttle rotates every cycle regardless of traffic; ready is the next bit 0
                    r_mask     <= {r_mask[6:0], r_mask[7]};
                    r_s_tready <= r_mask[7];
                    if (w_s_acc) begin
                        r_sum <= w_sum_next;
                        if (AXIS_S.TLAST) begin
                            r_flit_cnt <= '0;
                            r_pkt_bad  <= 1'b0;
                            r_pkt_cnt  <= w_pkt_next;
                            if (w_pkt_err) begin
                                r_err_cnt <= sat_inc16(r_err_cnt);
                            end
                            if (w_last_pkt) begin
                                r_state    <= SUM0;
                                r_s_tready <= 1'b0;
                                r_m_tvalid <= 1'b1;
                                r_m_tdata  <= w_sum_next;
                                r_m_tlast  <= 1'b0;
                            end
                        end else begin
                            r_flit_cnt <= sat_inc8(r_flit_cnt);
                            if (w_dest_bad) begin
                                r_pkt_bad <= 1'b1;
                            end
                        end
                    end
                end
                SUM0: begin
                    if (AXIS_M.TREADY) begin
                        r_m_tdata <= w_flit1;
                        r_m_tlast <= 1'b1;
                        r_state   <= SUM1;
                    end
                end
                SUM1: begin
                    if (AXIS_M.TREADY) begin
                        r_m_tvalid <= 1'b0;
                        r_m_tlast  <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign DONE          = r_done;
    assign AXIS_S.TREADY = r_s_tready;
    assign AXIS_M.TVALID = r_m_tvalid;
    assign AXIS_M.TDATA  = r_m_tdata;
    assign AXIS_M.TLAST  = r_m_tlast;
    assign AXIS_M.TDEST  = SUMMARY_DEST;
    assign AXIS_M.TID    = {TIDW{1'b0}};

endmodule

// File: tb/tb_axis_result_checker.sv
// Bench for axis_result_checker: three instances (default, throttled, single-packet) share one
// stimulus driver; a run table feeds flits and a scoreboard queue holds the expected summary flits.
module tb_axis_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic [3:0]  s_tdest = '0;
    logic        m_tready = 1'b1;

    logic        o_done, o_s_tready, o_m_tvalid, o_m_tlast;
    logic [31:0] o_m_tdata;
    logic [3:0]  o_m_tdest;
    logic        done_a, done_b, done_c;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_v_cyc = -1;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;

    typedef struct packed {
        logic [1:0]        sel;
        logic [4:0]        n;
        logic [3:0]        hold;
        logic [15:0]       last;
        logic [15:0][3:0]  dest;
        logic [15:0][31:0] data;
        logic [31:0]       exp0;
        logic [31:0]       exp1;
    } vec_t;
    vec_t vecs[6];

    axis_result_checker_if #(.TDATAW(32), .TDESTW(4), .TIDW(2)) sa(), ma(), sb(), mb(), sc(), mc();

    assign sa.TVALID = s_tvalid; assign sa.TDATA = s_tdata; assign sa.TLAST = s_tlast;
    assign sa.TDEST = s_tdest;   assign sa.TID = '0;        assign ma.TREADY = m_tready;
    assign sb.TVALID = s_tvalid; assign sb.TDATA = s_tdata; assign sb.TLAST = s_tlast;
    assign sb.TDEST = s_tdest;   assign sb.TID = '0;        assign mb.TREADY = m_tready;
    assign sc.TVALID = s_tvalid; assign sc.TDATA = s_tdata; assign sc.TLAST = s_tlast;
    assign sc.TDEST = s_tdest;   assign sc.TID = '0;        assign mc.TREADY = m_tready;

    axis_result_checker dut_a (
        .CLK(clk), .RST(rst), .START(start && (sel == 2'd0)), .DONE(done_a),
        .AXIS_S(sa), .AXIS_M(ma)
    );

    axis_result_checker #(.READY_PATTERN(8'b1010_0110)) dut_b (
        .CLK(clk), .RST(rst), .START(start && (sel == 2'd1)), .DONE(done_b),
        .AXIS_S(sb), .AXIS_M(mb)
    );

    axis_result_checker #(.NUM_PACKETS(1)) dut_c (
        .CLK(clk), .RST(rst), .START(start && (sel == 2'd2)), .DONE(done_c),
        .AXIS_S(sc), .AXIS_M(mc)
    );

    always_comb begin
        o_done = done_a; o_s_tready = sa.TREADY; o_m_tvalid = ma.TVALID;
        o_m_tdata = ma.TDATA; o_m_tlast = ma.TLAST; o_m_tdest = ma.TDEST;
        if (sel == 2'd1) begin
            o_done = done_b; o_s_tready = sb.TREADY; o_m_tvalid = mb.TVALID;
            o_m_tdata = mb.TDATA; o_m_tlast = mb.TLAST; o_m_tdest = mb.TDEST;
        end else if (sel == 2'd2) begin
            o_done = done_c; o_s_tready = sc.TREADY; o_m_tvalid = mc.TVALID;
            o_m_tdata = mc.TDATA; o_m_tlast = mc.TLAST; o_m_tdest = mc.TDEST;
        end
    end

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output monitor: sampled on the falling edge, scoreboard popped on each summary handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_m_tvalid && first_v_cyc < 0) first_v_cyc = cyc;
            if (o_m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_summary_flit", {31'd0, o_m_tvalid}, 64'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("summary_tdata", {32'd0, o_m_tdata}, {32'd0, e_mon.d});
                    chk("summary_tlast", {63'd0, o_m_tlast}, {63'd0, e_mon.l});
                    chk("summary_tdest", {60'd0, o_m_tdest}, 64'd0);
                end
            end
        end
    end

    task automatic fill_basic(output vec_t v);
        v = '0;
        v.n = 5'd8;
        for (int k = 0; k < 8; k++) begin
            v.data[k] = 32'(k + 1);
            v.dest[k] = 4'd3;
            v.last[k] = (k % 2 == 1);
        end
        v.exp0 = 32'd36;
        v.exp1 = 32'h0000_0004;
    endtask

    task automatic start_run(input logic [1:0] s);
        sel = s;
        done_cnt = 0;
        done_cyc = -1;
        first_v_cyc = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Drives every flit with TVALID held high; returns the cycle of the last acceptance
    task automatic feed(input vec_t v, output int t_acc);
        logic [7:0] mask;
        logic       rdy, acc;
        int         waitc;
        mask = (v.sel == 2'd1) ? 8'b1010_0110 : 8'hFF;
        for (int k = 0; k < int'(v.n); k++) begin
            s_tvalid = 1'b1;
            s_tdata  = v.data[k];
            s_tlast  = v.last[k];
            s_tdest  = v.dest[k];
            acc = 1'b0;
            waitc = 0;
            while (!acc && waitc < 40) begin
                if (v.sel == 2'd1) chk("tready_mask", {63'd0, o_s_tready}, {63'd0, mask[0]});
                rdy = o_s_tready;
                @(posedge clk); #1;
                mask = {mask[6:0], mask[7]};
                acc = rdy;
                waitc++;
            end
            if (!acc) chk("flit_accept_timeout", 64'd0, 64'd1);
        end
        t_acc = cyc;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   t_acc;
        exp_t e;
        m_tready = (v.hold == 4'd0);
        e.d = v.exp0; e.l = 1'b0; exp_q.push_back(e);
        e.d = v.exp1; e.l = 1'b1; exp_q.push_back(e);
        start_run(v.sel);
        feed(v, t_acc);
        chk("s_tready_after_last", {63'd0, o_s_tready}, 64'd0);
        for (int j = 0; j < int'(v.hold); j++) begin
            chk("sum0_hold_tvalid", {63'd0, o_m_tvalid}, 64'd1);
            chk("sum0_hold_tdata", {32'd0, o_m_tdata}, {32'd0, v.exp0});
            @(posedge clk); #1;
        end
        m_tready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
        end
        chk("m_tvalid_latency", 64'(first_v_cyc), 64'(t_acc));
        chk("done_pulse_count", 64'(done_cnt), 64'd1);
        if (v.hold == 4'd0) chk("done_latency", 64'(done_cyc), 64'(t_acc + 2));
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        vec_t v;
        int   t_acc;

        // Basic run, data 1..8 in four 2-flit packets
        fill_basic(v); vecs[0] = v;
        // Length errors: 1,1 | 5,5,5 | 7 | 1,1
        v = '0; v.n = 5'd8;
        v.data[0] = 1; v.data[1] = 1; v.data[2] = 5; v.data[3] = 5;
        v.data[4] = 5; v.data[5] = 7; v.data[6] = 1; v.data[7] = 1;
        for (int k = 0; k < 8; k++) v.dest[k] = 4'd3;
        v.last = 16'b0000_0000_1011_0010;
        v.exp0 = 32'd26; v.exp1 = 32'h0002_0004;
        vecs[1] = v;
        // Destination error on a non-last flit of packet 1
        fill_basic(v); v.dest[0] = 4'd2; v.exp1 = 32'h0001_0004; vecs[2] = v;
        // Destination error only on the last flit of packet 2
        fill_basic(v); v.dest[3] = 4'd2; v.exp1 = 32'h0001_0004; vecs[3] = v;
        // Throttled instance, summary stalled for 5 cycles
        fill_basic(v); v.sel = 2'd1; v.hold = 4'd5; vecs[4] = v;
        // Wrap-around on the single-packet instance
        v = '0; v.sel = 2'd2; v.n = 5'd2;
        v.data[0] = 32'hFFFF_FFFF; v.data[1] = 32'h0000_0003;
        v.dest[0] = 4'd3; v.dest[1] = 4'd3; v.last = 16'b10;
        v.exp0 = 32'h0000_0002; v.exp1 = 32'h0000_0001;
        vecs[5] = v;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_done", {63'd0, o_done}, 64'd0);
            chk("rst_s_tready", {63'd0, o_s_tready}, 64'd0);
            chk("rst_m_tvalid", {63'd0, o_m_tvalid}, 64'd0);
            chk("rst_m_tlast", {63'd0, o_m_tlast}, 64'd0);
            chk("rst_m_tdata", {32'd0, o_m_tdata}, 64'd0);
        end

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset while the first summary flit is stalled
        m_tready = 1'b0;
        start_run(2'd0);
        feed(vecs[0], t_acc);
        @(posedge clk); #1;
        chk("sum0_valid_before_rst", {63'd0, o_m_tvalid}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_m_tvalid", {63'd0, o_m_tvalid}, 64'd0);
        chk("rst_mid_m_tdata", {32'd0, o_m_tdata}, 64'd0);
        done_cnt = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
        m_tready = 1'b1;
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
